// File: rtl/seat_bank.sv
// seat_bank: per-seat stack / hole-card / betting-status bank behind one command port.
// Latency: single-cycle ops respond 1 cycle after accept; COLLECT responds NUM_SEATS+1 cycles after accept.
// Backpressure: cmd_ready is low for the whole COLLECT sweep; no response-side backpressure.
// Optional build macro SEAT_BANK_PROFIT_SAT_EN: overflowing PROFIT saturates instead of being dropped.

package seat_bank_pkg;
    localparam int MAX_STACK_W   = 11;
    localparam int DEFAULT_STACK = 1000;

    // Ranks 2..14 (Ace = 14); suits 0 clubs, 1 diamonds, 2 hearts, 3 spades.
    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
    } card_t;

    localparam logic [3:0] RANK_ACE    = 4'd14;
    localparam logic [1:0] SUIT_SPADES = 2'd3;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_SET_CARDS = 3'd1;
    localparam logic [2:0] OP_BET       = 3'd2;
    localparam logic [2:0] OP_PROFIT    = 3'd3;
    localparam logic [2:0] OP_FOLD      = 3'd4;
    localparam logic [2:0] OP_COLLECT   = 3'd5;
    localparam logic [2:0] OP_NEW_HAND  = 3'd6;
    localparam logic [2:0] OP_RSVD      = 3'd7;
endpackage

module seat_bank
    import seat_bank_pkg::*;
#(
    parameter int NUM_SEATS  = 4,
    parameter int STACK_W    = MAX_STACK_W,
    parameter int INIT_STACK = DEFAULT_STACK,
    // Derived widths; leave at their defaults.
    parameter int SEAT_W     = $clog2(NUM_SEATS),
    parameter int POT_W      = STACK_W + SEAT_W
) (
    input  logic                                  clk,
    input  logic                                  table_reset,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [2:0]                            cmd_op,
    input  logic [SEAT_W-1:0]                     cmd_seat,
    input  logic [STACK_W-1:0]                    cmd_amount,
    input  card_t [1:0]                           cmd_cards,
    output logic                                  rsp_valid,
    output logic [POT_W-1:0]                      rsp_amount,
    output logic                                  rsp_err,
    output logic [NUM_SEATS-1:0][STACK_W-1:0]     stacks,
    output logic [NUM_SEATS-1:0][STACK_W-1:0]     round_bet,
    output logic [NUM_SEATS-1:0]                  folded,
    output logic [NUM_SEATS-1:0]                  all_in,
    output card_t [NUM_SEATS-1:0][1:0]            cards,
    output logic [STACK_W-1:0]                    high_bet,
    output logic [POT_W-1:0]                      pot,
    output logic [SEAT_W:0]                       active_count
);

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    localparam logic [SEAT_W:0]    SEAT_LIMIT = (SEAT_W+1)'(NUM_SEATS);
    localparam logic [SEAT_W-1:0]  LAST_SEAT  = SEAT_W'(NUM_SEATS - 1);
    localparam logic [STACK_W-1:0] STACK_MAX  = '1;
    localparam logic [STACK_W-1:0] STACK_INIT = STACK_W'(INIT_STACK);
    localparam card_t              CARD_RESET = '{rank: RANK_ACE, suit: SUIT_SPADES};

    state_t              state;
    logic [SEAT_W-1:0]   sweep_idx;
    logic [POT_W-1:0]    sweep_total;

    logic                seat_ok;
    logic [STACK_W-1:0]  sel_stack;
    logic [STACK_W-1:0]  sel_bet;
    logic [STACK_W-1:0]  bet_amt;
    logic [STACK_W-1:0]  bet_total;
    logic [STACK_W:0]    profit_sum;
    logic [STACK_W-1:0]  profit_room;
    logic [STACK_W-1:0]  sweep_bet;

    assign cmd_ready = (state == ST_IDLE);

    // Seats beyond NUM_SEATS only exist when NUM_SEATS is not a power of two.
    assign seat_ok     = ({1'b0, cmd_seat} < SEAT_LIMIT);
    assign sel_stack   = stacks[cmd_seat];
    assign sel_bet     = round_bet[cmd_seat];
    // A bet larger than the stack is clipped to the stack (going all-in).
    assign bet_amt     = (cmd_amount > sel_stack) ? sel_stack : cmd_amount;
    assign bet_total   = sel_bet + bet_amt;
    // One extra bit so overflow shows up as the carry.
    assign profit_sum  = {1'b0, sel_stack} + {1'b0, cmd_amount};
    assign profit_room = STACK_MAX - sel_stack;
    assign sweep_bet   = round_bet[sweep_idx];

    // Command FSM: single-cycle ops in IDLE, one seat per cycle during the COLLECT sweep.
    always_ff @(posedge clk) begin
        if (table_reset) begin
            state        <= ST_IDLE;
            sweep_idx    <= '0;
            sweep_total  <= '0;
            for (int s = 0; s < NUM_SEATS; s++) begin
                stacks[s]    <= STACK_INIT;
                round_bet[s] <= '0;
                cards[s][0]  <= CARD_RESET;
                cards[s][1]  <= CARD_RESET;
            end
            folded       <= '0;
            all_in       <= '0;
            high_bet     <= '0;
            pot          <= '0;
            active_count <= SEAT_LIMIT;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_amount   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && (cmd_op != OP_NOP)) begin
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b0;
                        rsp_amount <= '0;
                        if (!seat_ok || (cmd_op == OP_RSVD)) begin
                            rsp_err <= 1'b1;
                        end else begin
                            case (cmd_op)
                                OP_SET_CARDS: begin
                                    cards[cmd_seat] <= cmd_cards;
                                end
                                OP_BET: begin
                                    if (folded[cmd_seat] || all_in[cmd_seat]) begin
                                        rsp_err <= 1'b1;
                                    end else begin
                                        stacks[cmd_seat]    <= sel_stack - bet_amt;
                                        round_bet[cmd_seat] <= bet_total;
                                        if (bet_amt == sel_stack)
                                            all_in[cmd_seat] <= 1'b1;
                                        if (bet_total > high_bet)
                                            high_bet <= bet_total;
                                        rsp_amount <= POT_W'(bet_amt);
                                    end
                                end
                                OP_PROFIT: begin
                                    if (!profit_sum[STACK_W]) begin
                                        stacks[cmd_seat] <= profit_sum[STACK_W-1:0];
                                        rsp_amount       <= POT_W'(cmd_amount);
                                    end else begin
`ifdef SEAT_BANK_PROFIT_SAT_EN
                                        stacks[cmd_seat] <= STACK_MAX;
                                        rsp_amount       <= POT_W'(profit_room);
`else
                                        rsp_err <= 1'b1;
`endif
                                    end
                                end
                                OP_FOLD: begin
                                    if (folded[cmd_seat]) begin
                                        rsp_err <= 1'b1;
                                    end else begin
                                        folded[cmd_seat] <= 1'b1;
                                        active_count     <= active_count - 1'b1;
                                    end
                                end
                                OP_COLLECT: begin
                                    // Response is deferred to the end of the sweep.
                                    rsp_valid   <= 1'b0;
                                    state       <= ST_SWEEP;
                                    sweep_idx   <= '0;
                                    sweep_total <= '0;
                                end
                                OP_NEW_HAND: begin
                                    for (int s = 0; s < NUM_SEATS; s++)
                                        round_bet[s] <= '0;
                                    folded       <= '0;
                                    all_in       <= '0;
                                    high_bet     <= '0;
                                    pot          <= '0;
                                    active_count <= SEAT_LIMIT;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                ST_SWEEP: begin
                    pot                  <= pot + POT_W'(sweep_bet);
                    round_bet[sweep_idx] <= '0;
                    if (sweep_idx == LAST_SEAT) begin
                        high_bet   <= '0;
                        state      <= ST_IDLE;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b0;
                        rsp_amount <= sweep_total + POT_W'(sweep_bet);
                    end else begin
                        sweep_idx   <= sweep_idx + 1'b1;
                        sweep_total <= sweep_total + POT_W'(sweep_bet);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seat_bank.sv
// Directed self-checking bench for seat_bank (4-seat main instance, 6-seat instance for bad seats).
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Expected values are hand-computed from the command sequence.

module tb_seat_bank;
    import seat_bank_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic table_reset;

    // 4-seat instance
    logic                  cmd_valid, cmd_ready;
    logic [2:0]            cmd_op;
    logic [1:0]            cmd_seat;
    logic [10:0]           cmd_amount;
    card_t [1:0]           cmd_cards;
    logic                  rsp_valid, rsp_err;
    logic [12:0]           rsp_amount;
    logic [3:0][10:0]      stacks, round_bet;
    logic [3:0]            folded, all_in;
    card_t [3:0][1:0]      cards;
    logic [10:0]           high_bet;
    logic [12:0]           pot;
    logic [2:0]            active_count;

    // 6-seat instance
    logic                  v6, rdy6;
    logic [2:0]            op6;
    logic [2:0]            seat6;
    logic [10:0]           amt6;
    card_t [1:0]           cards_in6;
    logic                  rv6, rerr6;
    logic [13:0]           ramt6;
    logic [5:0][10:0]      stacks6, bet6;
    logic [5:0]            folded6, allin6;
    card_t [5:0][1:0]      cards6;
    logic [10:0]           hb6;
    logic [13:0]           pot6;
    logic [3:0]            act6;

    int n_pass  = 0;
    int n_total = 0;

    seat_bank #(.NUM_SEATS(4), .STACK_W(11), .INIT_STACK(1000)) dut (
        .clk(clk), .table_reset(table_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_seat(cmd_seat), .cmd_amount(cmd_amount), .cmd_cards(cmd_cards),
        .rsp_valid(rsp_valid), .rsp_amount(rsp_amount), .rsp_err(rsp_err),
        .stacks(stacks), .round_bet(round_bet), .folded(folded), .all_in(all_in),
        .cards(cards), .high_bet(high_bet), .pot(pot), .active_count(active_count)
    );

    seat_bank #(.NUM_SEATS(6), .STACK_W(11), .INIT_STACK(1000)) dut6 (
        .clk(clk), .table_reset(table_reset),
        .cmd_valid(v6), .cmd_ready(rdy6), .cmd_op(op6),
        .cmd_seat(seat6), .cmd_amount(amt6), .cmd_cards(cards_in6),
        .rsp_valid(rv6), .rsp_amount(ramt6), .rsp_err(rerr6),
        .stacks(stacks6), .round_bet(bet6), .folded(folded6), .all_in(allin6),
        .cards(cards6), .high_bet(hb6), .pot(pot6), .active_count(act6)
    );

    // Present one command for exactly one edge; on return the response cycle is visible.
    task automatic issue(input logic [2:0] op, input logic [1:0] seat, input logic [10:0] amt);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_seat   = seat;
        cmd_amount = amt;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_op     = OP_NOP;
    endtask

    task automatic issue6(input logic [2:0] op, input logic [2:0] seat, input logic [10:0] amt);
        v6   = 1'b1;
        op6  = op;
        seat6 = seat;
        amt6 = amt;
        @(posedge clk);
        #1;
        v6   = 1'b0;
        op6  = OP_NOP;
    endtask

    task automatic do_reset();
        table_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        table_reset = 1'b0;
    endtask

    task automatic test_reset();
        card_t ace_s;
        ace_s = '{rank: RANK_ACE, suit: SUIT_SPADES};
        do_reset();
        n_total++; if (stacks !== {4{11'd1000}}) $display("FAIL reset_stacks got %h want all 1000", stacks); else n_pass++;
        n_total++; if (round_bet !== '0) $display("FAIL reset_round_bet got %h want 0", round_bet); else n_pass++;
        n_total++; if (folded !== 4'b0 || all_in !== 4'b0) $display("FAIL reset_flags got %b/%b want 0/0", folded, all_in); else n_pass++;
        n_total++; if (cards[2][0] !== ace_s || cards[3][1] !== ace_s) $display("FAIL reset_cards got %h/%h want %h", cards[2][0], cards[3][1], ace_s); else n_pass++;
        n_total++; if (high_bet !== 11'd0 || pot !== 13'd0) $display("FAIL reset_hb_pot got %0d/%0d want 0/0", high_bet, pot); else n_pass++;
        n_total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_amount !== 13'd0)
            $display("FAIL reset_port got rdy=%b rv=%b err=%b amt=%0d want 1/0/0/0", cmd_ready, rsp_valid, rsp_err, rsp_amount); else n_pass++;
        n_total++; if (active_count !== 3'd4) $display("FAIL reset_active got %0d want 4", active_count); else n_pass++;
    endtask

    task automatic test_bet();
        issue(OP_BET, 2'd1, 11'd200);
        n_total++; if (rsp_valid !== 1'b1 || rsp_amount !== 13'd200 || rsp_err !== 1'b0)
            $display("FAIL bet1_rsp got v=%b amt=%0d err=%b want 1/200/0", rsp_valid, rsp_amount, rsp_err); else n_pass++;
        n_total++; if (stacks[1] !== 11'd800 || round_bet[1] !== 11'd200 || high_bet !== 11'd200)
            $display("FAIL bet1_state got stk=%0d rb=%0d hb=%0d want 800/200/200", stacks[1], round_bet[1], high_bet); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL bet1_pulse got rsp_valid=%b want 0", rsp_valid); else n_pass++;

        issue(OP_BET, 2'd2, 11'd1500);
        n_total++; if (stacks[2] !== 11'd0 || round_bet[2] !== 11'd1000 || all_in[2] !== 1'b1 || rsp_amount !== 13'd1000)
            $display("FAIL bet_clip got stk=%0d rb=%0d ai=%b amt=%0d want 0/1000/1/1000", stacks[2], round_bet[2], all_in[2], rsp_amount); else n_pass++;
        n_total++; if (high_bet !== 11'd1000) $display("FAIL bet_clip_hb got %0d want 1000", high_bet); else n_pass++;

        issue(OP_BET, 2'd2, 11'd10);
        n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_amount !== 13'd0 || round_bet[2] !== 11'd1000 || stacks[2] !== 11'd0)
            $display("FAIL bet_allin_rej got err=%b amt=%0d rb=%0d stk=%0d want 1/0/1000/0", rsp_err, rsp_amount, round_bet[2], stacks[2]); else n_pass++;

        issue(OP_BET, 2'd0, 11'd0);
        n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_amount !== 13'd0 || all_in[0] !== 1'b0 || stacks[0] !== 11'd1000)
            $display("FAIL bet_zero got err=%b amt=%0d ai=%b stk=%0d want 0/0/0/1000", rsp_err, rsp_amount, all_in[0], stacks[0]); else n_pass++;

        issue(OP_BET, 2'd0, 11'd50);
        n_total++; if (round_bet[0] !== 11'd50 || stacks[0] !== 11'd950 || high_bet !== 11'd1000)
            $display("FAIL bet_seat0 got rb=%0d stk=%0d hb=%0d want 50/950/1000", round_bet[0], stacks[0], high_bet); else n_pass++;
    endtask

    task automatic test_collect();
        int lat;
        int low;
        cmd_valid = 1'b1; cmd_op = OP_COLLECT; cmd_seat = 2'd0; cmd_amount = 11'd0;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = OP_NOP;
        lat = 1; low = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            if (cmd_ready === 1'b0) low++;
            @(posedge clk); #1;
            lat++;
        end
        n_total++; if (lat !== 5) $display("FAIL collect_latency got %0d want 5", lat); else n_pass++;
        n_total++; if (low !== 4) $display("FAIL collect_ready_low got %0d cycles want 4", low); else n_pass++;
        n_total++; if (rsp_amount !== 13'd1250 || pot !== 13'd1250 || rsp_err !== 1'b0)
            $display("FAIL collect_amount got rsp=%0d pot=%0d err=%b want 1250/1250/0", rsp_amount, pot, rsp_err); else n_pass++;
        n_total++; if (round_bet !== '0 || high_bet !== 11'd0 || cmd_ready !== 1'b1)
            $display("FAIL collect_clear got rb=%h hb=%0d rdy=%b want 0/0/1", round_bet, high_bet, cmd_ready); else n_pass++;
        n_total++; if (stacks[0] !== 11'd950 || stacks[1] !== 11'd800 || stacks[2] !== 11'd0)
            $display("FAIL collect_stacks got %0d/%0d/%0d want 950/800/0", stacks[0], stacks[1], stacks[2]); else n_pass++;
    endtask

    task automatic test_profit();
        issue(OP_PROFIT, 2'd0, 11'd50);
        n_total++; if (stacks[0] !== 11'd1000 || rsp_amount !== 13'd50 || rsp_err !== 1'b0)
            $display("FAIL profit_plain got stk=%0d amt=%0d err=%b want 1000/50/0", stacks[0], rsp_amount, rsp_err); else n_pass++;

        issue(OP_PROFIT, 2'd0, 11'd1100);
`ifdef SEAT_BANK_PROFIT_SAT_EN
        n_total++; if (stacks[0] !== 11'd2047 || rsp_amount !== 13'd1047 || rsp_err !== 1'b0)
            $display("FAIL profit_ovf got stk=%0d amt=%0d err=%b want 2047/1047/0", stacks[0], rsp_amount, rsp_err); else n_pass++;
`else
        n_total++; if (stacks[0] !== 11'd1000 || rsp_amount !== 13'd0 || rsp_err !== 1'b1)
            $display("FAIL profit_ovf got stk=%0d amt=%0d err=%b want 1000/0/1", stacks[0], rsp_amount, rsp_err); else n_pass++;
`endif

        issue(OP_PROFIT, 2'd1, 11'd1247);
        n_total++; if (stacks[1] !== 11'd2047 || rsp_amount !== 13'd1247 || rsp_err !== 1'b0)
            $display("FAIL profit_exact_max got stk=%0d amt=%0d err=%b want 2047/1247/0", stacks[1], rsp_amount, rsp_err); else n_pass++;

        issue(OP_PROFIT, 2'd2, 11'd30);
        n_total++; if (stacks[2] !== 11'd30 || rsp_amount !== 13'd30 || all_in[2] !== 1'b1)
            $display("FAIL profit_allin got stk=%0d amt=%0d ai=%b want 30/30/1", stacks[2], rsp_amount, all_in[2]); else n_pass++;
    endtask

    task automatic test_cards_and_misc();
        card_t kh, qd;
        kh = '{rank: 4'd13, suit: 2'd2};
        qd = '{rank: 4'd12, suit: 2'd1};
        cmd_cards[0] = kh;
        cmd_cards[1] = qd;
        issue(OP_SET_CARDS, 2'd1, 11'd0);
        n_total++; if (cards[1][0] !== kh || cards[1][1] !== qd || rsp_amount !== 13'd0 || rsp_err !== 1'b0)
            $display("FAIL set_cards got %h/%h amt=%0d err=%b want %h/%h/0/0", cards[1][0], cards[1][1], rsp_amount, rsp_err, kh, qd); else n_pass++;

        issue(OP_RSVD, 2'd0, 11'd5);
        n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_amount !== 13'd0)
            $display("FAIL op_reserved got v=%b err=%b amt=%0d want 1/1/0", rsp_valid, rsp_err, rsp_amount); else n_pass++;

        issue(OP_NOP, 2'd0, 11'd5);
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL nop_no_rsp got rsp_valid=%b want 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_fold_new_hand();
        issue(OP_BET, 2'd3, 11'd100);
        issue(OP_FOLD, 2'd3, 11'd0);
        n_total++; if (active_count !== 3'd3 || folded[3] !== 1'b1 || rsp_err !== 1'b0)
            $display("FAIL fold1 got cnt=%0d fold=%b err=%b want 3/1/0", active_count, folded[3], rsp_err); else n_pass++;
        issue(OP_FOLD, 2'd3, 11'd0);
        n_total++; if (active_count !== 3'd3 || rsp_err !== 1'b1)
            $display("FAIL fold_twice got cnt=%0d err=%b want 3/1", active_count, rsp_err); else n_pass++;
        issue(OP_BET, 2'd3, 11'd10);
        n_total++; if (rsp_err !== 1'b1 || stacks[3] !== 11'd900)
            $display("FAIL bet_folded got err=%b stk=%0d want 1/900", rsp_err, stacks[3]); else n_pass++;

        issue(OP_NEW_HAND, 2'd0, 11'd0);
        n_total++; if (folded !== 4'b0 || all_in !== 4'b0 || active_count !== 3'd4 || pot !== 13'd0 || round_bet !== '0 || high_bet !== 11'd0)
            $display("FAIL new_hand got fold=%b ai=%b cnt=%0d pot=%0d hb=%0d want 0/0/4/0/0", folded, all_in, active_count, pot, high_bet); else n_pass++;
        n_total++; if (stacks[1] !== 11'd2047 || stacks[2] !== 11'd30 || stacks[3] !== 11'd900 || cards[1][0].rank !== 4'd13)
            $display("FAIL new_hand_keep got %0d/%0d/%0d rank=%0d want 2047/30/900/13", stacks[1], stacks[2], stacks[3], cards[1][0].rank); else n_pass++;
    endtask

    task automatic test_reset_mid_sweep();
        int seen;
        issue(OP_BET, 2'd0, 11'd100);
        cmd_valid = 1'b1; cmd_op = OP_COLLECT;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = OP_NOP;
        @(posedge clk); #1;
        n_total++; if (pot !== 13'd100 || cmd_ready !== 1'b0)
            $display("FAIL sweep_progress got pot=%0d rdy=%b want 100/0", pot, cmd_ready); else n_pass++;
        table_reset = 1'b1;
        @(posedge clk); #1;
        table_reset = 1'b0;
        n_total++; if (pot !== 13'd0 || round_bet !== '0 || stacks !== {4{11'd1000}} || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || active_count !== 3'd4)
            $display("FAIL reset_mid_sweep got pot=%0d rdy=%b rv=%b stk0=%0d want 0/1/0/1000", pot, cmd_ready, rsp_valid, stacks[0]); else n_pass++;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL reset_no_rsp got %0d responses want 0", seen); else n_pass++;
    endtask

    task automatic test_bad_seat();
        issue6(OP_BET, 3'd6, 11'd100);
        n_total++; if (rv6 !== 1'b1 || rerr6 !== 1'b1 || ramt6 !== 14'd0 || bet6 !== '0)
            $display("FAIL bad_seat got v=%b err=%b amt=%0d want 1/1/0", rv6, rerr6, ramt6); else n_pass++;
        issue6(OP_BET, 3'd5, 11'd100);
        n_total++; if (rerr6 !== 1'b0 || stacks6[5] !== 11'd900 || ramt6 !== 14'd100 || act6 !== 4'd6)
            $display("FAIL last_seat got err=%b stk=%0d amt=%0d cnt=%0d want 0/900/100/6", rerr6, stacks6[5], ramt6, act6); else n_pass++;
    endtask

    initial begin
        table_reset = 1'b0;
        cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_seat = '0; cmd_amount = '0; cmd_cards = '0;
        v6 = 1'b0; op6 = OP_NOP; seat6 = '0; amt6 = '0; cards_in6 = '0;
        #1;
        test_reset();
        test_bet();
        test_collect();
        test_profit();
        test_cards_and_misc();
        test_fold_new_hand();
        test_reset_mid_sweep();
        test_bad_seat();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop in case a wait above never completes.
    initial begin
        #200000;
        $display("FAIL timeout got no completion want finish");
        $fatal(1);
    end

endmodule
